// File: rtl/instr_encoder_loader.sv
// Buffers ALU-op requests, encodes each one as an RV32I R/I-type word and
// streams the words into instruction memory at consecutive addresses.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MAX_WORDS  = 256,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_alu_ctrl,
    input  logic        in_is_imm,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [11:0] in_imm,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int WC_W  = $clog2(MAX_WORDS + 1);
    localparam int REQ_W = 31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    logic [REQ_W-1:0] fifo_mem [FIFO_DEPTH];

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WC_W-1:0]  wcount_q, wcount_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             err_q, err_d;
    logic [7:0]       err_count_q, err_count_d;

    logic [REQ_W-1:0] req_in;
    logic [REQ_W-1:0] head;
    logic [2:0]       head_alu;
    logic             head_is_imm;
    logic [4:0]       head_rd;
    logic [4:0]       head_rs1;
    logic [4:0]       head_rs2;
    logic [11:0]      head_imm;
    logic             push;
    logic             pop;
    logic             illegal;
    logic [31:0]      committed;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      enc_word;

    assign req_in = {in_alu_ctrl, in_is_imm, in_rd, in_rs1, in_rs2, in_imm};
    assign head   = fifo_mem[rd_ptr_q];
    assign {head_alu, head_is_imm, head_rd, head_rs1, head_rs2, head_imm} = head;

    assign in_ready  = (count_q != CNT_W'(FIFO_DEPTH)) && (state_q != S_DONE) && !clear;
    assign push      = in_valid && in_ready;
    // Writes already done plus the one sitting in the output register; the
    // last permitted word must not be followed by another pop.
    assign committed = 32'(wcount_q) + 32'(mem_we_q);
    assign pop       = (state_q == S_RUN) && (count_q != '0) && !clear
                       && (committed < 32'(MAX_WORDS));
    assign illegal   = head_is_imm && (head_alu == 3'b001);

    assign mem_we    = mem_we_q && !clear;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign err_count = err_count_q;

    always_comb begin
        funct3   = 3'b000;
        funct7   = 7'b0000000;
        enc_word = 32'h0;
        case (head_alu)
            3'b000:  funct3 = 3'b000;
            3'b001:  begin funct3 = 3'b000; funct7 = 7'b0100000; end
            3'b101:  funct3 = 3'b010;
            3'b011:  funct3 = 3'b110;
            3'b010:  funct3 = 3'b111;
            3'b110:  funct3 = 3'b001;
            3'b100:  funct3 = 3'b100;
            default: funct3 = 3'b101;
        endcase
        if (head_is_imm) begin
            // Shift-immediates carry only a 5-bit shamt; upper bits forced to zero.
            if (head_alu == 3'b110 || head_alu == 3'b111) begin
                enc_word = {7'b0000000, head_imm[4:0], head_rs1, funct3, head_rd, 7'b0010011};
            end else begin
                enc_word = {head_imm, head_rs1, funct3, head_rd, 7'b0010011};
            end
        end else begin
            enc_word = {funct7, head_rs2, head_rs1, funct3, head_rd, 7'b0110011};
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wcount_d    = wcount_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        err_count_d = err_count_q;

        if (pop && !illegal) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_ADDR + {committed[29:0], 2'b00};
            mem_wdata_d = enc_word;
        end
        if (pop && illegal) begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end

        if (clear || state_q == S_DONE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        wcount_d = clear ? '0 : (wcount_q + WC_W'(mem_we_q));

        // IDLE/RUN mirror the next FIFO occupancy so a fresh entry pops at once.
        if (clear) begin
            state_d = S_IDLE;
        end else if (state_q == S_DONE
                     || (mem_we_q && (32'(wcount_q) + 32'd1 == 32'(MAX_WORDS)))) begin
            state_d = S_DONE;
        end else if (count_d != '0) begin
            state_d = S_RUN;
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= req_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wcount_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'h0;
            err_q       <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wcount_q    <= wcount_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 SHALL have parameter MAX_WORDS, default 256, number of words written before the block stops.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, request buffer depth (power of two).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous flush and address restart.
REQ-007 SHALL have port in_valid  input  1  request present.
REQ-008 SHALL have port in_ready  output  1  request accepted when high with in_valid.
REQ-009 SHALL have port in_alu_ctrl  input  3  ALU control code to encode.
REQ-010 SHALL have port in_is_imm  input  1  1 = I-type (opcode 0010011), 0 = R-type (opcode 0110011).
REQ-011 SHALL have port in_rd, in_rs1, in_rs2  input  5 each  register fields; in_rs2 is ignored for I-type.
REQ-012 SHALL have port in_imm  input  12  I-type immediate.
REQ-013 SHALL have port mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-014 SHALL have port mem_addr  output  32  byte write address.
REQ-015 SHALL have port mem_wdata  output  32  encoded instruction.
REQ-016 SHALL have port done  output  1  MAX_WORDS written.
REQ-017 SHALL have port err  output  1  sticky illegal-request flag.
REQ-018 SHALL have port err_count  output  8  saturating illegal-request count.

Function
REQ-019 SHALL map in_alu_ctrl to {funct3, funct7} as follows: 000 add {000,0000000}; 001 sub {000,0100000}; 101 slt {010,0}; 011 or {110,0}; 010 and {111,0}; 110 sll {001,0}; 100 xor {100,0}; 111 srl {101,0}.
REQ-020 SHALL encode R-type as {funct7, rs2, rs1, funct3, rd, 0110011}.
REQ-021 SHALL encode I-type as {in_imm, rs1, funct3, rd, 0010011}, except for sll/srl, which SHALL be {7'b0, in_imm[4:0], rs1, funct3, rd, 0010011}.
REQ-022 SHALL treat sub with in_is_imm=1 as illegal: the request is popped, no write occurs, the address does not advance, err is set and err_count is incremented (saturating at 255).
REQ-023 SHALL drive in_ready = !fifo_full && state!=DONE && !clear.
REQ-024 SHALL push a request into the FIFO on in_valid && in_ready; push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-025 SHALL, in RUN, pop one entry per cycle when the FIFO is non-empty, and register the encoded word so that mem_we is high in the cycle after the pop (a request accepted in cycle N writes in cycle N+2 when the FIFO was empty).
REQ-026 SHALL hold mem_addr = BASE_ADDR + 4*wcount, where wcount is the number of completed writes, incremented with each mem_we.
REQ-027 SHALL implement states IDLE (FIFO empty), RUN (FIFO non-empty), DONE (wcount==MAX_WORDS).
REQ-028 SHALL take transitions IDLE->RUN on non-empty, RUN->IDLE on empty, any->DONE on the write that makes wcount reach MAX_WORDS; DONE SHALL be left only by clear or reset.
REQ-029 SHALL, in DONE, drop the remaining FIFO entries unwritten and hold done=1.
REQ-030 SHALL, on clear, empty the FIFO, set wcount=0, go to IDLE and suppress mem_we that cycle; err and err_count SHALL be preserved; clear with in_valid SHALL accept nothing.
REQ-031 SHALL keep mem_addr/mem_wdata stable when mem_we=0.

Reset
REQ-032 SHALL, on reset (asynchronous, any state, mid-operation included), immediately force IDLE, empty FIFO, wcount=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, err=0, err_count=0; in_ready SHALL be 1 after reset deasserts.

Verification
REQ-033 SHALL verify R-type sub with rd=3, rs1=1, rs2=2 -> mem_wdata=32'h402081B3 at addr BASE_ADDR, mem_we two cycles after acceptance.
REQ-034 SHALL verify I-type srl with rd=5, rs1=6, imm=12'hFE3 -> mem_wdata=32'h00335293 (upper imm bits zeroed).
REQ-035 SHALL verify 6 back-to-back requests with FIFO_DEPTH=4 -> in_ready drops when full, all 6 written in order to consecutive addresses 0x0..0x14.
REQ-036 SHALL verify I-type sub, then add -> no write for sub, err=1, err_count=1, add written at BASE_ADDR.
REQ-037 SHALL verify MAX_WORDS=2 with 3 requests -> 2 writes, done=1, in_ready=0, third dropped; clear -> done=0, next write at BASE_ADDR.
REQ-038 SHALL verify reset asserted between pop and write -> no mem_we, all outputs at reset values asynchronously.
